axi_result_framer: RTL and testbench

//  Downstream stage of the ALU path. Drains 10-bit ALU results from the output FIFO (rvalid/rdata/rready).

---
 rtl/alu_frame_pkg.sv | 28 ++
 rtl/axi_out_reg.sv | 50 +++++
 rtl/axi_result_framer.sv | 199 +++++++++++++++++++
 tb/tb_axi_result_framer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_frame_pkg.sv
// ----------------------------------------------------------------------------
// alu_frame_pkg
//   Shared types and helpers for the ALU result framer.
//   - frm_state_t : framer FSM states
//   - FRM_SYNC    : sync nibble placed in bits [9:6] of every header word
//   - mk_header() : builds a header word {FRM_SYNC, seq, len-1}
// ----------------------------------------------------------------------------
package alu_frame_pkg;

    localparam int DATA_W = 10;
    localparam int SEQ_W  = 3;

    localparam logic [3:0] FRM_SYNC = 4'hA;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD,
        CSUM
    } frm_state_t;

    // len is the encoded payload length (PAYLOAD_LEN-1), not the raw count.
    function automatic logic [DATA_W-1:0] mk_header(input logic [SEQ_W-1:0] seq,
                                                    input logic [2:0]       len);
        return {FRM_SYNC, seq, len};
    endfunction

endpackage

// File: rtl/axi_out_reg.sv
// ----------------------------------------------------------------------------
// axi_out_reg
//   One-stage valid/ready output register. Holds wdata stable while the
//   downstream stalls and tells the producer when a new word may be loaded.
// Ports
//   clk          in   clock, posedge
//   reset        in   synchronous active-low reset
//   load_i       in   load load_data_i this cycle (only asserted when ld_ok_o)
//   load_data_i  in   word to load
//   wready_i     in   downstream accepts wdata_o
//   wvalid_o     out  output word valid
//   wdata_o      out  output word
//   ld_ok_o      out  register is free (empty, or draining this cycle)
// ----------------------------------------------------------------------------
module axi_out_reg
    import alu_frame_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              wready_i,
    output logic              wvalid_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              ld_ok_o
);

    logic              wvalid_q;
    logic [DATA_W-1:0] wdata_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wvalid_q <= 1'b0;
            wdata_q  <= '0;
        end else if (load_i) begin
            // A load in the same cycle as a handshake replaces the old word.
            wvalid_q <= 1'b1;
            wdata_q  <= load_data_i;
        end else if (wready_i) begin
            wvalid_q <= 1'b0;
        end
    end

    assign ld_ok_o  = !wvalid_q || wready_i;
    assign wvalid_o = wvalid_q;
    assign wdata_o  = wdata_q;

endmodule

// File: rtl/axi_result_framer.sv
// ----------------------------------------------------------------------------
// axi_result_framer
//   Drains 10-bit ALU results and emits fixed-length frames:
//   HEADER, PAYLOAD_LEN result words, CHECKSUM (XOR of payload words).
//   Optional feature macro FRAMER_TIMEOUT_EN: a partial frame idle for
//   TIMEOUT cycles is completed with zero pad words.
// Parameters
//   PAYLOAD_LEN  results per frame, 1..8
//   TIMEOUT      idle cycles before padding, 2..255 (FRAMER_TIMEOUT_EN only)
// Ports
//   clk         in   clock, posedge
//   reset       in   synchronous active-low reset
//   rvalid      in   result available upstream
//   rdata       in   result word
//   rready      out  framer takes rdata this cycle
//   wvalid      out  wdata valid
//   wdata       out  framed output word
//   wready      in   downstream accepts wdata
//   frame_done  out  pulse while the CHECKSUM word handshakes
//   frame_seq   out  sequence number of the frame in progress
// ----------------------------------------------------------------------------
module axi_result_framer
    import alu_frame_pkg::*;
#(
    parameter int PAYLOAD_LEN = 4
`ifdef FRAMER_TIMEOUT_EN
   ,parameter int TIMEOUT     = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rvalid,
    input  logic [DATA_W-1:0] rdata,
    output logic              rready,
    output logic              wvalid,
    output logic [DATA_W-1:0] wdata,
    input  logic              wready,
    output logic              frame_done,
    output logic [SEQ_W-1:0]  frame_seq
);

    localparam logic [2:0] LEN_FIELD = 3'(PAYLOAD_LEN - 1);
    localparam logic [3:0] CNT_LAST  = 4'(PAYLOAD_LEN - 1);

    frm_state_t        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    // Set while the checksum word sits in the output register, so the frame
    // is closed on its handshake rather than on its load.
    logic              csum_out_q, csum_out_d;

    logic              ld_ok;
    logic              out_load;
    logic [DATA_W-1:0] out_data;
    logic              word_done;
    logic              rready_c;
    logic              csum_hs;

`ifdef FRAMER_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT);
    logic [7:0] timer_q, timer_d;
    logic       timed_out;
`endif

    assign csum_hs = csum_out_q && wvalid && wready;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        csum_d     = csum_q;
        seq_d      = seq_q;
        csum_out_d = csum_out_q;
        out_load   = 1'b0;
        out_data   = '0;
        rready_c   = 1'b0;
        word_done  = 1'b0;
`ifdef FRAMER_TIMEOUT_EN
        timer_d    = '0;
        timed_out  = (timer_q == TIMEOUT_VAL);
`endif

        if (csum_hs) begin
            seq_d      = seq_q + 3'd1;
            csum_d     = '0;
            csum_out_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                // Wait for data; the word itself is consumed in PAYLOAD.
                if (rvalid) state_d = HDR;
            end

            HDR: begin
                // A header load can coincide with the previous checksum's
                // handshake, so it must use the already-advanced seq_d.
                if (ld_ok) begin
                    out_load = 1'b1;
                    out_data = mk_header(seq_d, LEN_FIELD);
                    state_d  = PAYLOAD;
                end
            end

            PAYLOAD: begin
`ifdef FRAMER_TIMEOUT_EN
                if (timed_out) begin
                    timer_d = timer_q;
                    if (ld_ok) begin
                        out_load  = 1'b1;
                        out_data  = '0;
                        word_done = 1'b1;
                    end
                end else begin
                    rready_c = ld_ok;
                    if (rvalid && ld_ok) begin
                        out_load  = 1'b1;
                        out_data  = rdata;
                        csum_d    = csum_q ^ rdata;
                        word_done = 1'b1;
                    end else if (cnt_q != 4'd0) begin
                        timer_d = timer_q + 8'd1;
                    end
                end
`else
                rready_c = ld_ok;
                if (rvalid && ld_ok) begin
                    out_load  = 1'b1;
                    out_data  = rdata;
                    csum_d    = csum_q ^ rdata;
                    word_done = 1'b1;
                end
`endif
                if (word_done) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = 4'd0;
                        state_d = CSUM;
`ifdef FRAMER_TIMEOUT_EN
                        timer_d = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            CSUM: begin
                if (ld_ok) begin
                    out_load   = 1'b1;
                    out_data   = csum_q;
                    csum_out_d = 1'b1;
                    state_d    = rvalid ? HDR : IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            csum_q     <= '0;
            seq_q      <= '0;
            csum_out_q <= 1'b0;
`ifdef FRAMER_TIMEOUT_EN
            timer_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            csum_q     <= csum_d;
            seq_q      <= seq_d;
            csum_out_q <= csum_out_d;
`ifdef FRAMER_TIMEOUT_EN
            timer_q    <= timer_d;
`endif
        end
    end

    axi_out_reg u_out_reg (
        .clk         (clk),
        .reset       (reset),
        .load_i      (out_load),
        .load_data_i (out_data),
        .wready_i    (wready),
        .wvalid_o    (wvalid),
        .wdata_o     (wdata),
        .ld_ok_o     (ld_ok)
    );

    assign rready     = rready_c;
    assign frame_done = csum_hs;
    assign frame_seq  = seq_q;

endmodule

// File: tb/tb_axi_result_framer.sv
// ----------------------------------------------------------------------------
// tb_axi_result_framer
//   Scoreboard bench for axi_result_framer (PAYLOAD_LEN=4, TIMEOUT=16).
//   The frame model turns each offered result into expected output words;
//   a monitor pops and compares on every output handshake.
// ----------------------------------------------------------------------------
module tb_axi_result_framer;

    localparam int LEN = 4;

    logic       clk;
    logic       reset;
    logic       rvalid;
    logic [9:0] rdata;
    logic       rready;
    logic       wvalid;
    logic [9:0] wdata;
    logic       wready;
    logic       frame_done;
    logic [2:0] frame_seq;

    axi_result_framer #(.PAYLOAD_LEN(LEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .rready     (rready),
        .wvalid     (wvalid),
        .wdata      (wdata),
        .wready     (wready),
        .frame_done (frame_done),
        .frame_seq  (frame_seq)
    );

    typedef struct {
        logic [9:0] data;
        logic       is_csum;
        logic [2:0] seq;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] src_q[$];
    logic [9:0] out_log[$];

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;

    logic [2:0] seq_m;
    logic [9:0] csum_m;
    int         pend_n;

    bit gap_en    = 0;
    bit wr_rand   = 0;
    int stall_req = 0;
    int stall_ack;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- frame model ----------------
    task automatic model_reset();
        exp_q.delete();
        out_log.delete();
        seq_m  = '0;
        csum_m = '0;
        pend_n = 0;
    endtask

    task automatic model_word(input logic [9:0] w);
        logic [9:0] hdr;
        if (pend_n == 0) begin
            hdr = {4'hA, seq_m, 3'(LEN - 1)};
            exp_q.push_back('{hdr, 1'b0, seq_m});
        end
        exp_q.push_back('{w, 1'b0, seq_m});
        csum_m = csum_m ^ w;
        pend_n++;
        if (pend_n == LEN) begin
            exp_q.push_back('{csum_m, 1'b1, seq_m});
            seq_m  = seq_m + 3'd1;
            csum_m = '0;
            pend_n = 0;
        end
    endtask

    task automatic push_word(input logic [9:0] w);
        model_word(w);
        src_q.push_back(w);
    endtask

    task automatic model_pad();
        while (pend_n != 0) model_word(10'h000);
    endtask

    // ---------------- downstream ready ----------------
    initial begin
        int hold;
        hold      = 0;
        stall_ack = 0;
        wready    = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_req != stall_ack) begin
                stall_ack = stall_req;
                hold      = 3;
            end
            if (hold > 0) begin
                wready = 1'b0;
                hold--;
            end else if (wr_rand) begin
                wready = ($urandom_range(0, 3) != 0);
            end else begin
                wready = 1'b1;
            end
        end
    end

    // ---------------- upstream source ----------------
    initial begin
        int n;
        bit ok;
        rvalid = 1'b0;
        rdata  = '0;
        forever begin
            if (src_q.size() == 0) begin
                rvalid = 1'b0;
                @(posedge clk);
                #1;
            end else if (gap_en && $urandom_range(0, 3) == 0) begin
                rvalid = 1'b0;
                @(posedge clk);
                #1;
            end else begin
                rvalid = 1'b1;
                rdata  = src_q[0];
                n      = 0;
                ok     = 0;
                while (!ok && n < 300) begin
                    @(negedge clk);
                    if (rready) ok = 1;
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("rdata_taken", 32'(ok), 1);
                void'(src_q.pop_front());
            end
        end
    end

    // Word accepted at a posedge must be on wdata one cycle later.
    logic       acc_q;
    logic [9:0] acc_w;
    always @(posedge clk) begin
        acc_q <= rvalid && rready && reset;
        acc_w <= rdata;
    end

    // ---------------- output monitor ----------------
    initial begin
        exp_t       e;
        logic [9:0] held;
        bit         stalled;
        stalled = 0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stalled = 0;
            end else begin
                if (acc_q) begin
                    check("latency_wvalid", 32'(wvalid), 1);
                    check("latency_wdata", 32'(wdata), 32'(acc_w));
                end
                if (stalled) begin
                    check("stall_wvalid", 32'(wvalid), 1);
                    check("stall_wdata", 32'(wdata), 32'(held));
                end
                if (wvalid && !wready) check("stall_rready", 32'(rready), 0);
                if (wvalid && wready) begin
                    check("word_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("wdata", 32'(wdata), 32'(e.data));
                        check("frame_done", 32'(frame_done), 32'(e.is_csum));
                        check("frame_seq", 32'(frame_seq), 32'(e.seq));
                        if (e.is_csum) done_cnt++;
                    end
                    out_log.push_back(wdata);
                end else begin
                    check("frame_done_quiet", 32'(frame_done), 0);
                end
                stalled = wvalid && !wready;
                held    = wdata;
            end
        end
    end

    // ---------------- sequencing helpers ----------------
    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 32'(exp_q.size() + src_q.size()), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        int n;
        n = 0;
        while (src_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_wvalid", 32'(wvalid), 0);
        check("rst_wdata", 32'(wdata), 0);
        check("rst_rready", 32'(rready), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_frame_seq", 32'(frame_seq), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [9:0] t1_exp [6];
        int         base;
        int         d0;
        int         n;

        reset = 1'b0;
        model_reset();
        @(posedge clk);
        do_reset();

        // Basic frame
        t1_exp = '{10'h283, 10'h005, 10'h00A, 10'h003, 10'h3FF, 10'h3F3};
        push_word(10'h005);
        push_word(10'h00A);
        push_word(10'h003);
        push_word(10'h3FF);
        wait_drain(200);
        check("t1_len", 32'(out_log.size()), 6);
        for (int i = 0; i < 6; i++)
            if (i < out_log.size()) check("t1_word", 32'(out_log[i]), 32'(t1_exp[i]));
        check("t1_done_cnt", 32'(done_cnt), 1);
        check("t1_seq", 32'(frame_seq), 1);

        // Back-to-back: second header follows the first checksum directly
        do_reset();
        for (int i = 0; i < 8; i++) push_word(10'($urandom_range(0, 1023)));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 200);
        check("t2_got_done", 32'(frame_done), 1);
        @(negedge clk);
        check("t2_hdr_valid", 32'(wvalid), 1);
        check("t2_hdr", 32'(wdata), 10'h28B);
        wait_drain(200);

        // Backpressure mid-payload
        base = out_log.size();
        for (int i = 0; i < 4; i++) push_word(10'($urandom_range(0, 1023)));
        n = 0;
        while (out_log.size() < base + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        stall_req = stall_req + 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(wvalid), 1);
            check("t3_rready", 32'(rready), 0);
        end
        wait_drain(200);

        // Sequence wrap: 9 frames with random gaps and stalls
        do_reset();
        d0      = done_cnt;
        gap_en  = 1;
        wr_rand = 1;
        for (int i = 0; i < 9 * LEN; i++) push_word(10'($urandom_range(0, 1023)));
        wait_drain(3000);
        gap_en  = 0;
        wr_rand = 0;
        check("t4_done_cnt", 32'(done_cnt - d0), 9);
        check("t4_log_len", 32'(out_log.size()), 54);
        if (out_log.size() > 48) check("t4_hdr9", 32'(out_log[48]), 10'h283);
        check("t4_seq", 32'(frame_seq), 1);

        // Partial frame followed by idle input
        base = out_log.size();
        push_word(10'h011);
        push_word(10'h022);
        wait_drain(200);
`ifdef FRAMER_TIMEOUT_EN
        repeat (10) @(negedge clk);
        model_pad();
        wait_drain(200);
        check("t5_len", 32'(out_log.size() - base), 6);
        if (out_log.size() > 0) check("t5_csum", 32'(out_log[out_log.size() - 1]), 10'h033);
`else
        repeat (40) @(negedge clk);
        check("t5_stall_wvalid", 32'(wvalid), 0);
        check("t5_stall_len", 32'(out_log.size() - base), 3);
`endif

        // Reset mid-payload drops the partial frame
        do_reset();
        push_word(10'h155);
        push_word(10'h2AA);
        wait_drain(200);
        do_reset();
        repeat (20) @(negedge clk);
        check("t6_quiet", 32'(out_log.size()), 0);
        for (int i = 0; i < 4; i++) push_word(10'($urandom_range(0, 1023)));
        wait_drain(200);
        check("t6_len", 32'(out_log.size()), 6);
        if (out_log.size() > 0) check("t6_hdr", 32'(out_log[0]), 10'h283);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
